// File: rtl/execute_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | execute_cycle : EX stage - operand forwarding, ALU, EX/MEM register.     |
// | MUL_ENABLE_EN : adds the iterative shift-add multiplier with stallE.     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module execute_cycle #(
  parameter int WIDTH   = 19,
  parameter int REGADDR = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   rd1E,
  input  logic [WIDTH-1:0]   rd2E,
  input  logic [WIDTH-1:0]   immextE,
  input  logic               alusrcE,
  input  logic [2:0]         aluctrlE,
  input  logic               regwriteE,
  input  logic               resultsrcE,
  input  logic               memwriteE,
  input  logic [REGADDR-1:0] rdE,
  input  logic               validE,
  input  logic               flushE,
  input  logic [1:0]         forwardAE,
  input  logic [1:0]         forwardBE,
  input  logic [WIDTH-1:0]   resultW,
  output logic [WIDTH-1:0]   aluresultM,
  output logic [WIDTH-1:0]   writedataM,
  output logic               regwriteM,
  output logic               resultsrcM,
  output logic               memwriteM,
  output logic [REGADDR-1:0] rdM,
  output logic               stallE
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SLT = 3'b101;
  localparam logic [2:0] c_OP_SHL = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  logic [WIDTH-1:0]   w_src_a;
  logic [WIDTH-1:0]   w_fwd_b;
  logic [WIDTH-1:0]   w_src_b;
  logic [WIDTH-1:0]   w_alu;
  logic               w_slt;
  logic               w_stall;
  logic               w_mul_out;
  logic [WIDTH-1:0]   w_m_res;
  logic [WIDTH-1:0]   w_m_wd;
  logic               w_m_regwrite;
  logic               w_m_resultsrc;
  logic               w_m_memwrite;
  logic [REGADDR-1:0] w_m_rd;

  // Encodings 00 and 11 both select the register-file operand.
  always_comb begin
    case (forwardAE)
      2'b01:   w_src_a = resultW;
      2'b10:   w_src_a = aluresultM;
      default: w_src_a = rd1E;
    endcase
    case (forwardBE)
      2'b01:   w_fwd_b = resultW;
      2'b10:   w_fwd_b = aluresultM;
      default: w_fwd_b = rd2E;
    endcase
    w_src_b = alusrcE ? immextE : w_fwd_b;
  end

  always_comb begin
    w_slt = $signed(w_src_a) < $signed(w_src_b);
    case (aluctrlE)
      c_OP_ADD: w_alu = w_src_a + w_src_b;
      c_OP_SUB: w_alu = w_src_a - w_src_b;
      c_OP_AND: w_alu = w_src_a & w_src_b;
      c_OP_OR:  w_alu = w_src_a | w_src_b;
      c_OP_XOR: w_alu = w_src_a ^ w_src_b;
      c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_SHL: w_alu = (w_src_b[4:0] >= 5'(WIDTH)) ? '0 : (w_src_a << w_src_b[4:0]);
      default:  w_alu = '0;  // MUL: product comes from the multiplier when present
    endcase
  end

`ifdef MUL_ENABLE_EN
  localparam int         c_CW     = $clog2(WIDTH);
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_BUSY = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               w_accept;
  logic [c_CW-1:0]    r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_wdata;
  logic               r_regwrite;
  logic               r_resultsrc;
  logic               r_memwrite;
  logic [REGADDR-1:0] r_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept) w_next = c_S_BUSY;
      c_S_BUSY: begin
        if (flushE)                                w_next = c_S_IDLE;
        else if (r_count == c_CW'(WIDTH-1))        w_next = c_S_DONE;
      end
      default:  w_next = c_S_IDLE;
    endcase
  end

  // A flush anywhere in the multiply drops the stall and the pending product.
  always_comb begin
    w_accept  = 1'b0;
    w_stall   = 1'b0;
    w_mul_out = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        w_accept = validE && (aluctrlE == c_OP_MUL) && !flushE;
        w_stall  = w_accept;
      end
      c_S_BUSY: w_stall   = !flushE;
      c_S_DONE: w_mul_out = !flushE;
      default:  w_stall   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_wdata     <= '0;
      r_regwrite  <= 1'b0;
      r_resultsrc <= 1'b0;
      r_memwrite  <= 1'b0;
      r_rd        <= '0;
    end else if (w_accept) begin
      r_count     <= '0;
      r_mcand     <= w_src_a;
      r_mplier    <= w_src_b;
      r_acc       <= '0;
      r_wdata     <= w_fwd_b;
      r_regwrite  <= regwriteE;
      r_resultsrc <= resultsrcE;
      r_memwrite  <= memwriteE;
      r_rd        <= rdE;
    end else if (r_state == c_S_BUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_count != c_CW'(WIDTH-1)) r_count <= r_count + 1'b1;
    end
  end
`else
  assign w_stall   = 1'b0;
  assign w_mul_out = 1'b0;
`endif

  always_comb begin
    w_m_res       = '0;
    w_m_wd        = '0;
    w_m_regwrite  = 1'b0;
    w_m_resultsrc = 1'b0;
    w_m_memwrite  = 1'b0;
    w_m_rd        = '0;
`ifdef MUL_ENABLE_EN
    if (w_mul_out) begin
      w_m_res       = r_acc;
      w_m_wd        = r_wdata;
      w_m_regwrite  = r_regwrite;
      w_m_resultsrc = r_resultsrc;
      w_m_memwrite  = r_memwrite;
      w_m_rd        = r_rd;
    end else
`endif
    if (validE && !flushE && !w_stall) begin
      w_m_res       = w_alu;
      w_m_wd        = w_fwd_b;
      w_m_regwrite  = regwriteE;
      w_m_resultsrc = resultsrcE;
      w_m_memwrite  = memwriteE;
      w_m_rd        = rdE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluresultM <= '0;
      writedataM <= '0;
      regwriteM  <= 1'b0;
      resultsrcM <= 1'b0;
      memwriteM  <= 1'b0;
      rdM        <= '0;
    end else begin
      aluresultM <= w_m_res;
      writedataM <= w_m_wd;
      regwriteM  <= w_m_regwrite;
      resultsrcM <= w_m_resultsrc;
      memwriteM  <= w_m_memwrite;
      rdM        <= w_m_rd;
    end
  end

  assign stallE = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_execute_cycle : directed vectors for the EX stage.                    |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] rd1E, rd2E, immextE, resultW;
  logic        alusrcE, regwriteE, resultsrcE, memwriteE, validE, flushE;
  logic [2:0]  aluctrlE, rdE;
  logic [1:0]  forwardAE, forwardBE;
  logic [18:0] aluresultM, writedataM;
  logic        regwriteM, resultsrcM, memwriteM, stallE;
  logic [2:0]  rdM;

  int n_vec = 0;
  int n_err = 0;

  execute_cycle #(.WIDTH(19), .REGADDR(3)) dut (
    .clk(clk), .rst(rst), .rd1E(rd1E), .rd2E(rd2E), .immextE(immextE),
    .alusrcE(alusrcE), .aluctrlE(aluctrlE), .regwriteE(regwriteE),
    .resultsrcE(resultsrcE), .memwriteE(memwriteE), .rdE(rdE), .validE(validE),
    .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
    .aluresultM(aluresultM), .writedataM(writedataM), .regwriteM(regwriteM),
    .resultsrcM(resultsrcM), .memwriteM(memwriteM), .rdM(rdM), .stallE(stallE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] ctl, input logic [18:0] a, input logic [18:0] b,
                        input logic [2:0] rd);
    aluctrlE = ctl; rd1E = a; rd2E = b; rdE = rd;
    validE = 1'b1; flushE = 1'b0; regwriteE = 1'b1; resultsrcE = 1'b0; memwriteE = 1'b0;
    alusrcE = 1'b0; forwardAE = 2'b00; forwardBE = 2'b00; immextE = '0; resultW = '0;
  endtask

  task automatic run_op(input string tag, input logic [18:0] exp_res, input logic [18:0] exp_wd,
                        input logic exp_rw, input logic [2:0] exp_rd);
    #1 chk({tag, ".stall"}, stallE, 0);
    @(posedge clk); #1;
    chk({tag, ".res"}, aluresultM, exp_res);
    chk({tag, ".wd"}, writedataM, exp_wd);
    chk({tag, ".rw"}, regwriteM, exp_rw);
    chk({tag, ".rd"}, rdM, exp_rd);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".res"}, aluresultM, 0);
    chk({tag, ".wd"}, writedataM, 0);
    chk({tag, ".rw"}, regwriteM, 0);
    chk({tag, ".rs"}, resultsrcM, 0);
    chk({tag, ".mw"}, memwriteM, 0);
    chk({tag, ".rd"}, rdM, 0);
    chk({tag, ".stall"}, stallE, 0);
  endtask

`ifdef MUL_ENABLE_EN
  // Stall must last 20 cycles with bubbles in M; upstream inputs are scrambled
  // after acceptance to show the latched operands and control are used.
  task automatic mul_run(input string tag, input logic [18:0] a, input logic [18:0] b,
                         input logic [18:0] exp, input logic [2:0] rd);
    int  nst;
    bit  done;
    nst = 0; done = 0;
    set_op(3'b111, a, b, rd);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stallE !== 1'b1) done = 1;
      else begin
        nst++;
        @(posedge clk); #1;
        chk({tag, ".bub"}, regwriteM, 0);
        rd1E = 19'd1; rd2E = 19'd2; rdE = 3'd0; regwriteE = 1'b0; aluctrlE = 3'b000;
      end
    end
    chk({tag, ".nstall"}, nst, 20);
    @(posedge clk); #1;
    chk({tag, ".res"}, aluresultM, exp);
    chk({tag, ".wd"}, writedataM, b);
    chk({tag, ".rw"}, regwriteM, 1);
    chk({tag, ".rd"}, rdM, rd);
  endtask
`endif

  initial begin
    set_op(3'b000, '0, '0, '0);
    validE = 1'b0; regwriteE = 1'b0;
    #12;
    chk_zero("reset");
    rst = 1'b1;

    set_op(3'b000, 19'd5, 19'd7, 3'd3); resultsrcE = 1'b1;
    run_op("add", 19'd12, 19'd7, 1'b1, 3'd3);
    chk("add.rs", resultsrcM, 1);
    chk("add.mw", memwriteM, 0);

    set_op(3'b001, 19'd3, 19'd5, 3'd1);          run_op("sub", 19'h7FFFE, 19'd5, 1'b1, 3'd1);
    set_op(3'b010, 19'h0F0F0, 19'h0FF00, 3'd2);  run_op("and", 19'h0F000, 19'h0FF00, 1'b1, 3'd2);
    set_op(3'b011, 19'h0F0F0, 19'h0FF00, 3'd2);  run_op("or",  19'h0FFF0, 19'h0FF00, 1'b1, 3'd2);
    set_op(3'b100, 19'h0F0F0, 19'h0FF00, 3'd2);  run_op("xor", 19'h00FF0, 19'h0FF00, 1'b1, 3'd2);
    set_op(3'b101, 19'h7FFFF, 19'd1, 3'd4);      run_op("slt_neg", 19'd1, 19'd1, 1'b1, 3'd4);
    set_op(3'b101, 19'd1, 19'h7FFFF, 3'd4);      run_op("slt_pos", 19'd0, 19'h7FFFF, 1'b1, 3'd4);
    set_op(3'b101, 19'd2, 19'd5, 3'd4);          run_op("slt_sm", 19'd1, 19'd5, 1'b1, 3'd4);
    set_op(3'b110, 19'd1, 19'd20, 3'd5);         run_op("shl20", 19'd0, 19'd20, 1'b1, 3'd5);
    set_op(3'b110, 19'd1, 19'd19, 3'd5);         run_op("shl19", 19'd0, 19'd19, 1'b1, 3'd5);
    set_op(3'b110, 19'd1, 19'd18, 3'd5);         run_op("shl18", 19'h40000, 19'd18, 1'b1, 3'd5);
    set_op(3'b110, 19'd3, 19'd4, 3'd5);          run_op("shl4", 19'h30, 19'd4, 1'b1, 3'd5);
    set_op(3'b110, 19'd1, 19'd35, 3'd5);         run_op("shl35", 19'd8, 19'd35, 1'b1, 3'd5);

    set_op(3'b000, 19'd10, 19'd20, 3'd2); regwriteE = 1'b0; memwriteE = 1'b1;
    run_op("sw", 19'd30, 19'd20, 1'b0, 3'd2);
    chk("sw.mw", memwriteM, 1);

    set_op(3'b000, 19'd1, 19'd2, 3'd7); validE = 1'b0; memwriteE = 1'b1; resultsrcE = 1'b1;
    run_op("inv", 19'd0, 19'd0, 1'b0, 3'd0);
    chk("inv.mw", memwriteM, 0);
    chk("inv.rs", resultsrcM, 0);
    set_op(3'b000, 19'd1, 19'd2, 3'd7); flushE = 1'b1; memwriteE = 1'b1;
    run_op("flush", 19'd0, 19'd0, 1'b0, 3'd0);
    chk("flush.mw", memwriteM, 0);

    set_op(3'b000, 19'd60, 19'd40, 3'd1);        run_op("pre1", 19'd100, 19'd40, 1'b1, 3'd1);
    set_op(3'b000, 19'd999, 19'd888, 3'd2);
    forwardAE = 2'b10; forwardBE = 2'b01; resultW = 19'd23;
    run_op("fwd", 19'd123, 19'd23, 1'b1, 3'd2);
    set_op(3'b000, 19'd60, 19'd40, 3'd1);        run_op("pre2", 19'd100, 19'd40, 1'b1, 3'd1);
    set_op(3'b000, 19'd999, 19'd888, 3'd4);
    forwardAE = 2'b10; forwardBE = 2'b01; resultW = 19'd23; alusrcE = 1'b1; immextE = 19'd4;
    run_op("fwdimm", 19'd104, 19'd23, 1'b1, 3'd4);
    set_op(3'b001, 19'd999, 19'd5, 3'd3); forwardAE = 2'b01; resultW = 19'd50;
    run_op("fwdw", 19'd45, 19'd5, 1'b1, 3'd3);
    set_op(3'b000, 19'd7, 19'd1, 3'd3); forwardAE = 2'b11; forwardBE = 2'b11; resultW = 19'd50;
    run_op("fwd11", 19'd8, 19'd1, 1'b1, 3'd3);

    // Asynchronous reset between edges clears a live result at once.
    set_op(3'b000, 19'd9, 19'd9, 3'd6); memwriteE = 1'b1; resultsrcE = 1'b1;
    run_op("prerst", 19'd18, 19'd9, 1'b1, 3'd6);
    #2 rst = 1'b0;
    #1 chk_zero("arst");
    #1 rst = 1'b1;
    set_op(3'b000, 19'd2, 19'd3, 3'd1);          run_op("postrst", 19'd5, 19'd3, 1'b1, 3'd1);

`ifdef MUL_ENABLE_EN
    mul_run("mul", 19'd300, 19'd500, 19'd150000, 3'd5);
    mul_run("mulb2b", 19'd1000, 19'd1000, 19'd475712, 3'd6);

    set_op(3'b111, 19'd300, 19'd500, 3'd5);
    #1 chk("mfl.acc", stallE, 1);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 flushE = 1'b1;
    #1 chk("mfl.stall", stallE, 0);
    @(posedge clk); #1;
    chk("mfl.rw", regwriteM, 0);
    chk("mfl.res", aluresultM, 0);
    set_op(3'b000, 19'd2, 19'd3, 3'd2);          run_op("postfl", 19'd5, 19'd3, 1'b1, 3'd2);

    set_op(3'b111, 19'd300, 19'd500, 3'd5);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 chk("mrst.busy", stallE, 1);
    #1 rst = 1'b0;
    #1 chk_zero("mrst");
    #1 rst = 1'b1;
    set_op(3'b000, 19'd4, 19'd6, 3'd3);          run_op("postmrst", 19'd10, 19'd6, 1'b1, 3'd3);
`else
    set_op(3'b111, 19'd300, 19'd500, 3'd5);      run_op("mul0", 19'd0, 19'd500, 1'b1, 3'd5);
    set_op(3'b000, 19'd4, 19'd6, 3'd3);          run_op("postmul", 19'd10, 19'd6, 1'b1, 3'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
